// File: rtl/vc_inflight_squash_unit.sv
// vc_inflight_squash_unit: forwards memory requests, tracks in-flight count, and discards responses outstanding at a squash
module vc_inflight_squash_unit #(
    parameter int p_req_nbits    = 1,
    parameter int p_resp_nbits   = 1,
    parameter int p_max_inflight = 4,
    localparam int c_cnt_nbits   = $clog2(p_max_inflight + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    domain,
    input  logic                    squash,
    input  logic [p_req_nbits-1:0]  req_in_msg,
    input  logic                    req_in_val,
    output logic                    req_in_rdy,
    output logic [p_req_nbits-1:0]  req_out_msg,
    output logic                    req_out_val,
    input  logic                    req_out_rdy,
    input  logic [p_resp_nbits-1:0] resp_in_msg,
    input  logic                    resp_in_val,
    output logic                    resp_in_rdy,
    output logic [p_resp_nbits-1:0] resp_out_msg,
    output logic                    resp_out_val,
    input  logic                    resp_out_rdy,
    output logic [c_cnt_nbits-1:0]  inflight,
    output logic                    drop_busy
);
    logic [c_cnt_nbits-1:0] inflight_cnt, inflight_nxt, drop_cnt, drop_nxt;
    logic full, req_go, resp_go, unused_domain;

    assign unused_domain = domain;
    assign full          = inflight_cnt == c_cnt_nbits'(p_max_inflight);
    assign drop_busy     = drop_cnt != '0;
    assign inflight      = inflight_cnt;
    assign req_out_msg   = req_in_msg;
    assign req_out_val   = req_in_val & ~full & ~squash;
    assign req_in_rdy    = req_out_rdy & ~full & ~squash;
    assign req_go        = req_in_val & req_in_rdy;
    assign resp_out_msg  = resp_in_msg;
    assign resp_out_val  = ~drop_busy & resp_in_val & ~squash;
    assign resp_in_rdy   = drop_busy | squash | resp_out_rdy;
    assign resp_go       = resp_in_val & resp_in_rdy;

    // next counts: inflight clamps at zero on a stray response; a squash recomputes drop_cnt from inflight
    always_comb begin
        inflight_nxt = inflight_cnt;
        if (req_go && !resp_go) inflight_nxt = inflight_cnt + 1'b1;
        else if (resp_go && !req_go && inflight_cnt != '0) inflight_nxt = inflight_cnt - 1'b1;
        drop_nxt = drop_cnt;
        if (squash) drop_nxt = (resp_go && inflight_cnt != '0) ? inflight_cnt - 1'b1 : inflight_cnt;
        else if (drop_busy && resp_go) drop_nxt = drop_cnt - 1'b1;
    end

    // counter registers with synchronous active-low reset overriding everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            inflight_cnt <= inflight_nxt;
            drop_cnt     <= drop_nxt;
        end
    end
endmodule

// File: tb/tb_vc_inflight_squash_unit.sv
// tb_vc_inflight_squash_unit: directed scoreboard bench for the in-flight squash unit
module tb_vc_inflight_squash_unit;
    logic       clk = 0, reset = 0, domain = 0, squash = 0;
    logic [7:0] req_in_msg = 0, req_out_msg, resp_in_msg = 0, resp_out_msg;
    logic       req_in_val = 0, req_in_rdy, req_out_val, req_out_rdy = 1;
    logic       resp_in_val = 0, resp_in_rdy, resp_out_val, resp_out_rdy = 1;
    logic [2:0] inflight;
    logic       drop_busy;
    int         n_chk = 0, n_pass = 0, n_fail = 0;

    typedef struct {logic val; logic rdy; logic [7:0] msg;} exp_t;
    exp_t sb[$];

    vc_inflight_squash_unit #(.p_req_nbits(8), .p_resp_nbits(8), .p_max_inflight(4)) dut (
        .clk(clk), .reset(reset), .domain(domain), .squash(squash),
        .req_in_msg(req_in_msg), .req_in_val(req_in_val), .req_in_rdy(req_in_rdy),
        .req_out_msg(req_out_msg), .req_out_val(req_out_val), .req_out_rdy(req_out_rdy),
        .resp_in_msg(resp_in_msg), .resp_in_val(resp_in_val), .resp_in_rdy(resp_in_rdy),
        .resp_out_msg(resp_out_msg), .resp_out_val(resp_out_val), .resp_out_rdy(resp_out_rdy),
        .inflight(inflight), .drop_busy(drop_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic state(input string tag, input logic [2:0] e_inf, input logic e_busy);
        chk({tag, "_inflight"}, inflight, e_inf);
        chk({tag, "_drop_busy"}, drop_busy, e_busy);
    endtask

    task automatic req(input logic [7:0] m, input logic e_go);
        req_in_val = 1;
        req_in_msg = m;
        #1;
        chk("req_out_val", req_out_val, e_go);
        chk("req_in_rdy", req_in_rdy, e_go);
        if (e_go) chk("req_out_msg", req_out_msg, m);
        tick();
        req_in_val = 0;
    endtask

    task automatic resp(input logic [7:0] m, input logic ordy, input logic e_val, input logic e_rdy);
        exp_t e;
        resp_in_val = 1;
        resp_in_msg = m;
        resp_out_rdy = ordy;
        sb.push_back('{val: e_val, rdy: e_rdy, msg: m});
        #1;
        e = sb.pop_front();
        chk("resp_out_val", resp_out_val, e.val);
        chk("resp_in_rdy", resp_in_rdy, e.rdy);
        if (e.val) chk("resp_out_msg", resp_out_msg, e.msg);
        tick();
        resp_in_val = 0;
        resp_out_rdy = 1;
    endtask

    initial begin
        tick();
        tick();
        state("reset", 3'd0, 1'b0);
        reset = 1;
        tick();
        // fill to the limit, then the fifth request is blocked
        req(8'h11, 1);
        req(8'h12, 1);
        req(8'h13, 1);
        state("three_req", 3'd3, 1'b0);
        req(8'h14, 1);
        state("four_req", 3'd4, 1'b0);
        req(8'h15, 0);
        state("full_block", 3'd4, 1'b0);
        // pass-mode drain, first with backpressure from the pipeline
        resp(8'hA0, 0, 1, 0);
        state("resp_backpressure", 3'd4, 1'b0);
        resp(8'hA1, 1, 1, 1);
        resp(8'hA2, 1, 1, 1);
        resp(8'hA3, 1, 1, 1);
        resp(8'hA4, 1, 1, 1);
        state("drained", 3'd0, 1'b0);
        // squash with two outstanding, no response in the squash cycle
        req(8'h21, 1);
        req(8'h22, 1);
        squash = 1;
        #1;
        chk("squash_req_in_rdy", req_in_rdy, 1'b0);
        tick();
        squash = 0;
        state("squash2", 3'd2, 1'b1);
        resp(8'hB0, 0, 0, 1);
        resp(8'hB1, 1, 0, 1);
        state("after_drops", 3'd0, 1'b0);
        resp(8'hB2, 1, 1, 1);
        state("underflow_hold", 3'd0, 1'b0);
        // squash coinciding with a response
        req(8'h31, 1);
        req(8'h32, 1);
        squash = 1;
        resp(8'hC0, 1, 0, 1);
        squash = 0;
        state("squash_with_resp", 3'd1, 1'b1);
        resp(8'hC1, 1, 0, 1);
        state("single_drop_done", 3'd0, 1'b0);
        // second squash during drop mode recomputes from inflight
        req(8'h41, 1);
        req(8'h42, 1);
        squash = 1;
        tick();
        squash = 0;
        req(8'h43, 1);
        state("req_while_drop", 3'd3, 1'b1);
        squash = 1;
        tick();
        squash = 0;
        state("resquash", 3'd3, 1'b1);
        resp(8'hD0, 1, 0, 1);
        resp(8'hD1, 1, 0, 1);
        resp(8'hD2, 1, 0, 1);
        state("three_dropped", 3'd0, 1'b0);
        req(8'h44, 1);
        resp(8'hD3, 1, 1, 1);
        state("post_resquash", 3'd0, 1'b0);
        // request in a squash cycle is held off, then issues
        squash = 1;
        req(8'h51, 0);
        squash = 0;
        state("squash_req", 3'd0, 1'b0);
        req(8'h51, 1);
        state("req_after_squash", 3'd1, 1'b0);
        resp(8'hE0, 1, 1, 1);
        // reset in the middle of a drop
        req(8'h61, 1);
        req(8'h62, 1);
        squash = 1;
        tick();
        squash = 0;
        state("pre_reset_drop", 3'd2, 1'b1);
        reset = 0;
        tick();
        reset = 1;
        state("mid_drop_reset", 3'd0, 1'b0);
        resp(8'hF0, 1, 1, 1);
        state("after_reset_resp", 3'd0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
